// File: rtl/set_job_sched.sv
// set_job_sched: front-end scheduler for the SET point-counting engine.
// Two level-sensitive requesters are arbitrated round-robin. One engine job
// runs at a time, and its operands are held stable for the whole job. The
// candidate count is returned tagged with the requester id. A RUN-cycle
// watchdog reports a hung job, and the engine is then drained before the
// next grant.
module set_job_sched #(
    parameter logic [8:0] TIMEOUT = 9'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] cen0,
    input  logic [23:0] cen1,
    input  logic [11:0] rad0,
    input  logic [11:0] rad1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    output logic        ack0,
    output logic        ack1,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  job_cnt,
    output logic [3:0]  err_cnt,
    output logic        eng_en,
    output logic [23:0] eng_central,
    output logic [11:0] eng_radius,
    output logic [1:0]  eng_mode,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        take_s;      // a grant happens this cycle (IDLE -> LOAD)
    logic        grant_s;     // granted requester id
    logic        hit_s;       // engine answered in RUN
    logic        tmo_s;       // watchdog expired in RUN
    logic        ptr_r;       // round-robin pointer: preferred requester on a tie
    logic [8:0]  timer_r;
    logic        id_r;
    logic [23:0] cen_r;
    logic [11:0] rad_r;
    logic [1:0]  mode_r;
    logic        ack0_r;
    logic        ack1_r;
    logic        eng_en_r;
    logic        rsp_valid_r;
    logic        rsp_id_r;
    logic [7:0]  rsp_data_r;
    logic        rsp_err_r;
    logic [7:0]  job_cnt_r;
    logic [3:0]  err_cnt_r;

    // Next-state decode, arbitration and job-completion qualifiers.
    always_comb begin
        state_s = state_r;
        take_s  = 1'b0;
        grant_s = 1'b0;
        hit_s   = 1'b0;
        tmo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    take_s  = 1'b1;
                    // req1 wins when alone, or on a tie when the pointer favours it
                    grant_s = req1 & (~req0 | ptr_r);
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = RUN;
            end
            RUN: begin
                // a result in the timeout cycle still counts as a success
                if (eng_valid) begin
                    hit_s   = 1'b1;
                    state_s = RESP;
                end else if (timer_r == TIMEOUT) begin
                    tmo_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = RUN;
                end
            end
            RESP: begin
                if (rsp_err_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (eng_valid) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, round-robin pointer and RUN-cycle watchdog timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
            timer_r <= 9'd0;
        end else begin
            state_r <= state_s;
            if (take_s) begin
                ptr_r <= ~grant_s;
            end
            // timer reads k in the k-th RUN cycle
            if (state_r == LOAD) begin
                timer_r <= 9'd1;
            end else if (state_r == RUN) begin
                timer_r <= timer_r + 9'd1;
            end
        end
    end

    // Operand holding registers: written only on the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r   <= 1'b0;
            cen_r  <= 24'd0;
            rad_r  <= 12'd0;
            mode_r <= 2'd0;
        end else if (take_s) begin
            id_r   <= grant_s;
            cen_r  <= grant_s ? cen1  : cen0;
            rad_r  <= grant_s ? rad1  : rad0;
            mode_r <= grant_s ? mode1 : mode0;
        end
    end

    // One-cycle strobes: ack/eng_en during LOAD, rsp_valid during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            eng_en_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            ack0_r      <= take_s & ~grant_s;
            ack1_r      <= take_s & grant_s;
            eng_en_r    <= take_s;
            rsp_valid_r <= hit_s | tmo_s;
        end
    end

    // Response fields and counters, updated as RESP is entered so they are
    // valid alongside the rsp_valid pulse and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id_r   <= 1'b0;
            rsp_data_r <= 8'd0;
            rsp_err_r  <= 1'b0;
            job_cnt_r  <= 8'd0;
            err_cnt_r  <= 4'd0;
        end else if (hit_s) begin
            rsp_id_r   <= id_r;
            rsp_data_r <= eng_candidate;
            rsp_err_r  <= 1'b0;
            job_cnt_r  <= job_cnt_r + 8'd1;
        end else if (tmo_s) begin
            rsp_id_r   <= id_r;
            rsp_data_r <= 8'd0;
            rsp_err_r  <= 1'b1;
            if (err_cnt_r != 4'd15) begin
                err_cnt_r <= err_cnt_r + 4'd1;
            end
        end
    end

    assign ack0        = ack0_r;
    assign ack1        = ack1_r;
    assign eng_en      = eng_en_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = rsp_id_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_err     = rsp_err_r;
    assign job_cnt     = job_cnt_r;
    assign err_cnt     = err_cnt_r;
    assign eng_central = cen_r;
    assign eng_radius  = rad_r;
    assign eng_mode    = mode_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_set_job_sched.sv
// Bench for set_job_sched: random requesters plus an engine model, checked
// every cycle against a job-level timeline model (grant, response and idle
// times computed from the engine latency with plain arithmetic).
module tb_set_job_sched;

    localparam int TMO    = 255;
    localparam int N_JOBS = 40;
    localparam int RST_G  = 30;
    localparam int MAXC   = 60000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [23:0] cen0, cen1;
    logic [11:0] rad0, rad1;
    logic [1:0]  mode0, mode1;
    logic        ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, eng_en, eng_valid;
    logic [7:0]  rsp_data, job_cnt, eng_candidate;
    logic [3:0]  err_cnt;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;

    set_job_sched #(.TIMEOUT(9'd255)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .cen0(cen0), .cen1(cen1),
        .rad0(rad0), .rad1(rad1), .mode0(mode0), .mode1(mode1),
        .ack0(ack0), .ack1(ack1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .job_cnt(job_cnt), .err_cnt(err_cnt), .eng_en(eng_en),
        .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
        .eng_valid(eng_valid), .eng_candidate(eng_candidate)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // requesters
    bit          pend [2];
    logic [23:0] p_cen [2];
    logic [11:0] p_rad [2];
    logic [1:0]  p_mode [2];
    bit          raise_block;

    // job timeline of the current/last job
    int          L, V, R, free_at, job_g, ngrant;
    bit          job_w, job_err, ptr, rst_done;
    logic [7:0]  job_data;
    logic [23:0] nxt_cen;
    logic [11:0] nxt_rad;
    logic [1:0]  nxt_mode;

    // expected held outputs
    logic [23:0] e_cen;
    logic [11:0] e_rad;
    logic [1:0]  e_mode;
    bit          e_id, e_err;
    logic [7:0]  e_data;
    int          e_job, e_errc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat_for(input int g, input logic [1:0] m);
        int r;
        int nominal;
        nominal = (m == 2'd0) ? 65 : ((m == 2'd3) ? 193 : 129);
        if (g == 0) return 65;
        if (g == 5) return 300;
        if (g == 6) return TMO;
        if (g == 7) return TMO - 1;
        if (g == RST_G) return 100;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return nominal;
        if (r == 6) return int'($urandom_range(1, TMO));
        if (r == 7) return TMO;
        if (r == 8) return int'($urandom_range(TMO + 2, TMO + 40));
        return int'($urandom_range(1, 20));
    endfunction

    task automatic model_reset();
        L = -1; V = -1; R = -1; free_at = 0; ptr = 1'b0;
        e_cen = 24'd0; e_rad = 12'd0; e_mode = 2'd0;
        e_id = 1'b0; e_err = 1'b0; e_data = 8'd0; e_job = 0; e_errc = 0;
    endtask

    task automatic new_ops(input int i);
        p_cen[i]  = 24'($urandom);
        p_rad[i]  = 12'($urandom);
        p_mode[i] = 2'($urandom);
    endtask

    task automatic check_outputs(input int n);
        if (n == L) begin
            e_cen = nxt_cen; e_rad = nxt_rad; e_mode = nxt_mode;
        end
        if (n == R) begin
            e_id   = job_w;
            e_err  = job_err;
            e_data = job_err ? 8'd0 : job_data;
            if (job_err) e_errc = (e_errc == 15) ? 15 : e_errc + 1;
            else         e_job  = (e_job + 1) % 256;
        end
        check_eq("ack0",        32'(ack0),        32'(n == L && !job_w));
        check_eq("ack1",        32'(ack1),        32'(n == L && job_w));
        check_eq("eng_en",      32'(eng_en),      32'(n == L));
        check_eq("busy",        32'(busy),        32'(L >= 0 && n >= L && n < free_at));
        check_eq("rsp_valid",   32'(rsp_valid),   32'(n == R));
        check_eq("rsp_id",      32'(rsp_id),      32'(e_id));
        check_eq("rsp_data",    32'(rsp_data),    32'(e_data));
        check_eq("rsp_err",     32'(rsp_err),     32'(e_err));
        check_eq("job_cnt",     32'(job_cnt),     32'(e_job));
        check_eq("err_cnt",     32'(err_cnt),     32'(e_errc));
        check_eq("eng_central", 32'(eng_central), 32'(e_cen));
        check_eq("eng_radius",  32'(eng_radius),  32'(e_rad));
        check_eq("eng_mode",    32'(eng_mode),    32'(e_mode));
    endtask

    task automatic drive_and_grant(input int n);
        bit raise;
        bit w;
        int lat;
        if (n == L) pend[job_w] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!pend[i]) begin
                if (raise_block || ngrant >= N_JOBS) raise = 1'b0;
                else if (ngrant == 0)                raise = (i == 0 && n >= 10);
                else if (ngrant < 8)                 raise = 1'b1;
                else                                 raise = ($urandom_range(0, 7) == 0);
                if (raise) begin
                    pend[i] = 1'b1;
                    if (ngrant == 0) begin
                        p_cen[i] = 24'h123456; p_rad[i] = 12'h345; p_mode[i] = 2'd0;
                    end else begin
                        new_ops(i);
                    end
                end
            end
        end
        req0  = pend[0];
        req1  = pend[1];
        cen0  = pend[0] ? p_cen[0]  : 24'($urandom);
        cen1  = pend[1] ? p_cen[1]  : 24'($urandom);
        rad0  = pend[0] ? p_rad[0]  : 12'($urandom);
        rad1  = pend[1] ? p_rad[1]  : 12'($urandom);
        mode0 = pend[0] ? p_mode[0] : 2'($urandom);
        mode1 = pend[1] ? p_mode[1] : 2'($urandom);
        eng_valid     = (n == V);
        eng_candidate = (n == V) ? job_data : 8'($urandom);
        if (n >= free_at && (pend[0] || pend[1])) begin
            w        = (pend[0] && pend[1]) ? ptr : (pend[0] ? 1'b0 : 1'b1);
            ptr      = ~w;
            job_w    = w;
            L        = n + 1;
            nxt_cen  = p_cen[w];
            nxt_rad  = p_rad[w];
            nxt_mode = p_mode[w];
            job_g    = ngrant;
            lat      = lat_for(ngrant, p_mode[w]);
            if (ngrant == 0)      job_data = 8'h1A;
            else if (ngrant == 5) job_data = 8'h55;
            else if (ngrant == 6) job_data = 8'h07;
            else                  job_data = 8'($urandom);
            V = L + lat;
            if (lat <= TMO) begin
                job_err = 1'b0; R = V + 1; free_at = V + 2;
            end else begin
                job_err = 1'b1; R = L + TMO + 1; free_at = V + 1;
            end
            ngrant++;
            raise_block = 1'b0;
        end
    endtask

    // Reset in the middle of a RUN: job dropped, pending req1 alone afterwards.
    task automatic mid_reset();
        rst = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b1; new_ops(1);
        raise_block = 1'b1;
        req0 = 1'b0; req1 = 1'b1;
        cen1 = p_cen[1]; rad1 = p_rad[1]; mode1 = p_mode[1];
        eng_valid = 1'b0;
        #1;
        model_reset();
        check_outputs(cyc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc++;
            check_outputs(cyc);
        end
        rst = 1'b0;
        rst_done = 1'b1;
        free_at = cyc;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        cen0 = 24'd0; cen1 = 24'd0; rad0 = 12'd0; rad1 = 12'd0;
        mode0 = 2'd0; mode1 = 2'd0;
        eng_valid = 1'b0; eng_candidate = 8'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        raise_block = 1'b0; rst_done = 1'b0;
        ngrant = 0; job_g = -1; job_w = 1'b0; job_err = 1'b0; job_data = 8'd0;
        nxt_cen = 24'd0; nxt_rad = 12'd0; nxt_mode = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (1) begin
            check_outputs(cyc);
            if (ngrant >= N_JOBS && rst_done && cyc >= free_at) break;
            if (!rst_done && L >= 0 && job_g == RST_G && cyc == L + 40) mid_reset();
            drive_and_grant(cyc);
            @(negedge clk);
            cyc++;
            if (cyc > MAXC) begin
                n_cmp++;
                n_bad++;
                $display("FAIL cycle_budget cyc=%0d grants=%0d required=%0d", cyc, ngrant, N_JOBS);
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
